// File: rtl/cpu_run_controller_if.sv
// Signal bundle between the RV32 core/board and the run/halt/step controller.
// The master side is the core plus board I/O; the slave side is the controller.
interface cpu_run_controller_if #(
   parameter int CNT_W = 32
);
   logic             run_sw;
   logic             step_btn;
   logic             bp_en;
   logic [31:0]      bp_addr;
   logic [31:0]      pc;
   logic [31:0]      inst;
   logic             cnt_clr;
   logic             cpu_en;
   logic [1:0]       state;
   logic             halted;
   logic [1:0]       halt_cause;
   logic [CNT_W-1:0] retire_cnt;

   modport master (
      output run_sw, step_btn, bp_en, bp_addr, pc, inst, cnt_clr,
      input  cpu_en, state, halted, halt_cause, retire_cnt
   );

   modport slave (
      input  run_sw, step_btn, bp_en, bp_addr, pc, inst, cnt_clr,
      output cpu_en, state, halted, halt_cause, retire_cnt
   );
endinterface

// File: rtl/cpu_run_controller.sv
// Run/halt/single-step sequencer for the single-cycle RV32 core: gates commits via
// cpu_en, traps on PC breakpoint and EBREAK, debounces the step button, counts retires.
module cpu_run_controller #(
   parameter int CNT_W      = 32,
   parameter int DEB_CYCLES = 16
) (
   input logic                 clk,
   input logic                 rst,
   cpu_run_controller_if.slave bus
);

   typedef enum logic [1:0] {
      StHalt = 2'b00,
      StRun  = 2'b01,
      StStep = 2'b10,
      StBrk  = 2'b11
   } runState_e;

   localparam logic [31:0]      EbreakInst  = 32'h0010_0073;
   localparam logic [15:0]      DebLast     = 16'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);
   localparam logic [1:0]       CauseNone   = 2'b00;
   localparam logic [1:0]       CauseUser   = 2'b01;
   localparam logic [1:0]       CauseBp     = 2'b10;
   localparam logic [1:0]       CauseEbreak = 2'b11;

   logic             runMeta_q;
   logic             runSync_q;
   logic             stepMeta_q;
   logic             stepSync_q;
   logic [15:0]      debCnt_q;
   logic [15:0]      debCnt_d;
   logic             debLvl_q;
   logic             debLvl_d;
   logic             debLvlPrev_q;
   runState_e        state_q;
   logic             halted_q;
   logic [1:0]       haltCause_q;
   logic [CNT_W-1:0] retireCnt_q;

   logic ebreakHit;
   logic bpHit;
   logic stepPulse;
   logic cpuEn;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         runMeta_q  <= 1'b0;
         runSync_q  <= 1'b0;
         stepMeta_q <= 1'b0;
         stepSync_q <= 1'b0;
      end else begin
         runMeta_q  <= bus.run_sw;
         runSync_q  <= runMeta_q;
         stepMeta_q <= bus.step_btn;
         stepSync_q <= stepMeta_q;
      end
   end

   // The level only flips after DEB_CYCLES consecutive samples disagreeing with it.
   always_comb begin
      debCnt_d = debCnt_q;
      debLvl_d = debLvl_q;
      if (stepSync_q == debLvl_q) begin
         debCnt_d = '0;
      end else if (debCnt_q == DebLast) begin
         debLvl_d = stepSync_q;
         debCnt_d = '0;
      end else begin
         debCnt_d = debCnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         debCnt_q     <= '0;
         debLvl_q     <= 1'b0;
         debLvlPrev_q <= 1'b0;
      end else begin
         debCnt_q     <= debCnt_d;
         debLvl_q     <= debLvl_d;
         debLvlPrev_q <= debLvl_q;
      end
   end

   assign stepPulse = debLvl_q & ~debLvlPrev_q;
   assign ebreakHit = (bus.inst == EbreakInst);
   assign bpHit     = bus.bp_en && (bus.pc == bus.bp_addr);

   always_comb begin
      cpuEn = 1'b0;
      unique case (state_q)
         StRun:   cpuEn = ~ebreakHit & ~bpHit & runSync_q;
         StStep:  cpuEn = ~ebreakHit;
         default: cpuEn = 1'b0;
      endcase
   end

   // STEP ignores the breakpoint so the user can step off it; a pending step
   // pulse outside HALT/BRK is simply dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StHalt;
         halted_q    <= 1'b1;
         haltCause_q <= CauseNone;
      end else begin
         unique case (state_q)
            StHalt: begin
               if (runSync_q) begin
                  state_q     <= StRun;
                  halted_q    <= 1'b0;
                  haltCause_q <= CauseNone;
               end else if (stepPulse) begin
                  state_q     <= StStep;
                  halted_q    <= 1'b0;
                  haltCause_q <= CauseNone;
               end
            end
            StRun: begin
               if (ebreakHit) begin
                  state_q     <= StBrk;
                  halted_q    <= 1'b1;
                  haltCause_q <= CauseEbreak;
               end else if (bpHit) begin
                  state_q     <= StBrk;
                  halted_q    <= 1'b1;
                  haltCause_q <= CauseBp;
               end else if (!runSync_q) begin
                  state_q     <= StHalt;
                  halted_q    <= 1'b1;
                  haltCause_q <= CauseUser;
               end
            end
            StStep: begin
               halted_q <= 1'b1;
               if (ebreakHit) begin
                  state_q     <= StBrk;
                  haltCause_q <= CauseEbreak;
               end else begin
                  state_q <= StHalt;
               end
            end
            StBrk: begin
               if (stepPulse) begin
                  state_q     <= StStep;
                  halted_q    <= 1'b0;
                  haltCause_q <= CauseNone;
               end else if (!runSync_q) begin
                  state_q <= StHalt;
               end
            end
            default: begin
               state_q  <= StHalt;
               halted_q <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retireCnt_q <= '0;
      end else if (bus.cnt_clr) begin
         retireCnt_q <= '0;
      end else if (cpuEn) begin
         retireCnt_q <= retireCnt_q + CntOne;
      end
   end

   assign bus.cpu_en     = cpuEn;
   assign bus.state      = state_q;
   assign bus.halted     = halted_q;
   assign bus.halt_cause = haltCause_q;
   assign bus.retire_cnt = retireCnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: directed board scenarios plus random stimulus, all
// checked every cycle against a behavioural model of the run/step/trap rules.
module tb_cpu_run_controller;

   localparam int          CntW       = 6;
   localparam int          DebCycles  = 4;
   localparam logic [31:0] EbreakInst = 32'h0010_0073;
   localparam logic [31:0] NopInst    = 32'h0000_0013;
   localparam int          ModeHalt   = 0;
   localparam int          ModeRun    = 1;
   localparam int          ModeStep   = 2;
   localparam int          ModeBrk    = 3;

   logic clk = 1'b0;
   logic rst;

   cpu_run_controller_if #(.CNT_W(CntW)) bus ();

   cpu_run_controller #(
      .CNT_W      (CntW),
      .DEB_CYCLES (DebCycles)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Abort guard so the run always ends even if a loop misbehaves.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   int compared   = 0;
   int mismatched = 0;
   int cycleNum   = 0;

   // Model: mode/cause/count plus raw input histories for synchronisers and debounce.
   int          mMode;
   int          mCause;
   int          mCnt;
   bit          rawRun[$];
   bit          rawStep[$];
   bit          dbSamples[$];
   bit          mLvl;
   bit          mLvlPrev;
   logic [31:0] ebreakAddr;

   logic            seenEn;
   logic [1:0]      seenState;
   logic [1:0]      seenCause;
   logic [CntW-1:0] seenCnt;
   logic [31:0]     seenPc;

   function automatic void modelReset();
      mMode    = ModeHalt;
      mCause   = 0;
      mCnt     = 0;
      rawRun   = {1'b0, 1'b0};
      rawStep  = {1'b0, 1'b0};
      dbSamples.delete();
      mLvl     = 1'b0;
      mLvlPrev = 1'b0;
   endfunction

   function automatic bit modelEnable();
      bit eb;
      bit bp;
      eb = (bus.inst == EbreakInst);
      bp = bus.bp_en && (bus.pc == bus.bp_addr);
      if (mMode == ModeRun)  return rawRun[1] && !eb && !bp;
      if (mMode == ModeStep) return !eb;
      return 1'b0;
   endfunction

   function automatic bit modelAdvance();
      bit runS;
      bit pulse;
      bit eb;
      bit bp;
      bit en;
      bit allDiffer;
      int nextMode;
      int nextCause;
      runS      = rawRun[1];
      pulse     = mLvl && !mLvlPrev;
      eb        = (bus.inst == EbreakInst);
      bp        = bus.bp_en && (bus.pc == bus.bp_addr);
      en        = modelEnable();
      nextMode  = mMode;
      nextCause = mCause;
      case (mMode)
         ModeHalt: begin
            if (runS) nextMode = ModeRun;
            else if (pulse) nextMode = ModeStep;
         end
         ModeRun: begin
            if (eb) begin nextMode = ModeBrk; nextCause = 3; end
            else if (bp) begin nextMode = ModeBrk; nextCause = 2; end
            else if (!runS) begin nextMode = ModeHalt; nextCause = 1; end
         end
         ModeStep: begin
            if (eb) begin nextMode = ModeBrk; nextCause = 3; end
            else nextMode = ModeHalt;
         end
         default: begin
            if (pulse) nextMode = ModeStep;
            else if (!runS) nextMode = ModeHalt;
         end
      endcase
      if ((nextMode == ModeRun || nextMode == ModeStep) && nextMode != mMode) nextCause = 0;
      if (bus.cnt_clr) mCnt = 0;
      else if (en) mCnt = (mCnt + 1) % (1 << CntW);
      dbSamples.push_back(rawStep[1]);
      if (dbSamples.size() > DebCycles) void'(dbSamples.pop_front());
      allDiffer = (dbSamples.size() == DebCycles);
      foreach (dbSamples[i]) if (dbSamples[i] == mLvl) allDiffer = 1'b0;
      mLvlPrev = mLvl;
      if (allDiffer) mLvl = !mLvl;
      rawRun.push_front(bus.run_sw);
      void'(rawRun.pop_back());
      rawStep.push_front(bus.step_btn);
      void'(rawStep.pop_back());
      mMode  = nextMode;
      mCause = nextCause;
      return en;
   endfunction

   function automatic logic [31:0] progInst(input logic [31:0] addr);
      return (addr == ebreakAddr) ? EbreakInst : NopInst;
   endfunction

   task automatic checkOutput(input string name, input longint got, input longint want);
      compared++;
      if (got != want) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cycleNum);
      end
   endtask

   task automatic checkModel();
      checkOutput("cpu_en", bus.cpu_en, modelEnable());
      checkOutput("state", bus.state, mMode);
      checkOutput("halted", bus.halted, (mMode == ModeHalt || mMode == ModeBrk));
      checkOutput("halt_cause", bus.halt_cause, mCause);
      checkOutput("retire_cnt", bus.retire_cnt, mCnt);
   endtask

   // One clock cycle: sample and check mid-cycle, advance the model, then act as the
   // core (PC steps by 4 on each commit) at the following falling edge.
   task automatic applyStimulus();
      bit en;
      #1;
      seenEn    = bus.cpu_en;
      seenState = bus.state;
      seenCause = bus.halt_cause;
      seenCnt   = bus.retire_cnt;
      seenPc    = bus.pc;
      checkModel();
      if (rst) begin
         modelReset();
         en = 1'b0;
      end else begin
         en = modelAdvance();
      end
      @(posedge clk);
      @(negedge clk);
      cycleNum++;
      if (en) bus.pc = bus.pc + 32'd4;
      bus.inst = progInst(bus.pc);
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   initial begin
      int  firstIdx;
      int  commits;
      int  stateAtCommit;
      bit  found;
      bit  sawStep;

      rst          = 1'b1;
      ebreakAddr   = 32'hFFFF_FFF0;
      bus.run_sw   = 1'b0;
      bus.step_btn = 1'b0;
      bus.bp_en    = 1'b0;
      bus.bp_addr  = 32'h0;
      bus.pc       = 32'h0;
      bus.inst     = NopInst;
      bus.cnt_clr  = 1'b0;
      modelReset();

      #2;
      checkOutput("reset_state", bus.state, 0);
      checkOutput("reset_halted", bus.halted, 1);
      checkOutput("reset_cpu_en", bus.cpu_en, 0);
      checkOutput("reset_cause", bus.halt_cause, 0);
      checkOutput("reset_cnt", bus.retire_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      runCycles(3);

      // Clean step press: single commit seven cycles after the edge.
      bus.step_btn  = 1'b1;
      firstIdx      = -1;
      commits       = 0;
      stateAtCommit = 0;
      for (int i = 0; i < 14; i++) begin
         applyStimulus();
         if (seenEn) begin
            commits++;
            if (firstIdx < 0) begin
               firstIdx      = i;
               stateAtCommit = seenState;
            end
         end
      end
      checkOutput("step_latency", firstIdx, 7);
      checkOutput("step_commits", commits, 1);
      checkOutput("step_state", stateAtCommit, 2);
      checkOutput("step_cnt", bus.retire_cnt, 1);
      checkOutput("step_back_halt", bus.state, 0);
      checkOutput("step_cause", bus.halt_cause, 0);
      bus.step_btn = 1'b0;
      runCycles(10);

      // Bouncy press: three toggles two cycles apart, then held high.
      commits = 0;
      bus.step_btn = 1'b1;
      for (int i = 0; i < 2; i++) begin applyStimulus(); commits += int'(seenEn); end
      bus.step_btn = 1'b0;
      for (int i = 0; i < 2; i++) begin applyStimulus(); commits += int'(seenEn); end
      bus.step_btn = 1'b1;
      for (int i = 0; i < 16; i++) begin applyStimulus(); commits += int'(seenEn); end
      checkOutput("bounce_commits", commits, 1);
      checkOutput("bounce_cnt", bus.retire_cnt, 2);
      bus.step_btn = 1'b0;
      runCycles(10);

      // Free run from PC 0 into a breakpoint at 0x10.
      bus.pc      = 32'h0;
      bus.inst    = progInst(bus.pc);
      bus.cnt_clr = 1'b1;
      applyStimulus();
      bus.cnt_clr = 1'b0;
      bus.bp_en   = 1'b1;
      bus.bp_addr = 32'h0000_0010;
      bus.run_sw  = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         applyStimulus();
         if (seenState == 2'd3) found = 1'b1;
      end
      checkOutput("bp_reached", found, 1);
      checkOutput("bp_pc", seenPc, 32'h10);
      checkOutput("bp_cpu_en", seenEn, 0);
      checkOutput("bp_cnt", seenCnt, 4);
      checkOutput("bp_cause", seenCause, 2);

      // Step off the breakpoint with run_sw still high: BRK -> STEP -> HALT -> RUN.
      bus.step_btn = 1'b1;
      found   = 1'b0;
      sawStep = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         applyStimulus();
         if (seenState == 2'd2) begin
            sawStep = 1'b1;
            checkOutput("bpstep_pc", seenPc, 32'h10);
            checkOutput("bpstep_en", seenEn, 1);
         end else if (sawStep && seenState == 2'd0) begin
            checkOutput("bpstep_halt_pc", seenPc, 32'h14);
            checkOutput("bpstep_halt_cnt", seenCnt, 5);
            checkOutput("bpstep_halt_cause", seenCause, 0);
         end else if (sawStep && seenState == 2'd1) begin
            checkOutput("bpstep_run_cause", seenCause, 0);
            found = 1'b1;
         end
      end
      checkOutput("bpstep_resumed", found, 1);
      bus.step_btn = 1'b0;

      // EBREAK at 0x20 traps; a step afterwards commits nothing and re-traps.
      ebreakAddr = 32'h0000_0020;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         applyStimulus();
         if (seenState == 2'd3) found = 1'b1;
      end
      checkOutput("ebreak_reached", found, 1);
      checkOutput("ebreak_pc", seenPc, 32'h20);
      checkOutput("ebreak_en", seenEn, 0);
      checkOutput("ebreak_cause", seenCause, 3);
      checkOutput("ebreak_cnt", seenCnt, 8);
      runCycles(8);
      bus.step_btn = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         applyStimulus();
         if (seenState == 2'd2) begin
            checkOutput("ebreak_step_en", seenEn, 0);
            applyStimulus();
            checkOutput("ebreak_rebrk_state", seenState, 3);
            checkOutput("ebreak_rebrk_cause", seenCause, 3);
            found = 1'b1;
         end
      end
      checkOutput("ebreak_step_seen", found, 1);
      checkOutput("ebreak_step_cnt", bus.retire_cnt, 8);
      bus.step_btn = 1'b0;
      runCycles(8);

      // Only reset leaves an EBREAK trap; then run until the counter wraps.
      rst = 1'b1;
      modelReset();
      runCycles(2);
      ebreakAddr = 32'hFFFF_FFF0;
      bus.inst   = progInst(bus.pc);
      bus.bp_en  = 1'b0;
      rst        = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 150 && !found; i++) begin
         applyStimulus();
         if (seenCnt == '1 && seenEn) begin
            checkOutput("wrap_cnt", bus.retire_cnt, 0);
            found = 1'b1;
         end
      end
      checkOutput("wrap_seen", found, 1);
      runCycles(3);

      // Reset mid-cycle while running: outputs drop without waiting for a clock.
      #3;
      checkOutput("prereset_en", bus.cpu_en, 1);
      rst = 1'b1;
      #1;
      checkOutput("midreset_state", bus.state, 0);
      checkOutput("midreset_en", bus.cpu_en, 0);
      checkOutput("midreset_cnt", bus.retire_cnt, 0);
      checkOutput("midreset_halted", bus.halted, 1);
      modelReset();
      @(negedge clk);
      applyStimulus();
      rst = 1'b0;

      // Random traffic on every input, checked against the model each cycle.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            rst = 1'b1;
            modelReset();
         end else begin
            rst = 1'b0;
         end
         if ($urandom_range(0, 24) == 0) bus.run_sw = ~bus.run_sw;
         if ($urandom_range(0, 5) == 0) bus.step_btn = ~bus.step_btn;
         bus.bp_en   = 1'($urandom_range(0, 1));
         bus.bp_addr = bus.pc + 32'(4 * $urandom_range(0, 3));
         bus.cnt_clr = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 29) == 0) bus.pc = 32'({$urandom_range(0, 63), 2'b00});
         if ($urandom_range(0, 39) == 0) bus.inst = EbreakInst;
         else bus.inst = ($urandom() & ~32'h7F) | 32'h13;
         applyStimulus();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
